// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths for the register-file read path
package regfile_pkg;
    localparam int DATA_W  = 16;
    localparam int NREGS   = 16;
    localparam int RADDR_W = 4;
endpackage

// File: rtl/regfile_sel.sv
// regfile_sel: 16:1 register mux with same-cycle write forwarding
module regfile_sel #(
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic [regfile_pkg::RADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]               r0,
    input  logic [DATA_W-1:0]               r1,
    input  logic [DATA_W-1:0]               r2,
    input  logic [DATA_W-1:0]               r3,
    input  logic [DATA_W-1:0]               r4,
    input  logic [DATA_W-1:0]               r5,
    input  logic [DATA_W-1:0]               r6,
    input  logic [DATA_W-1:0]               r7,
    input  logic [DATA_W-1:0]               r8,
    input  logic [DATA_W-1:0]               r9,
    input  logic [DATA_W-1:0]               r10,
    input  logic [DATA_W-1:0]               r11,
    input  logic [DATA_W-1:0]               r12,
    input  logic [DATA_W-1:0]               r13,
    input  logic [DATA_W-1:0]               r14,
    input  logic [DATA_W-1:0]               r15,
    input  logic [DATA_W-1:0]               ALUBus,
    input  logic [regfile_pkg::NREGS-1:0]   regEnable,
    output logic [DATA_W-1:0]               sel
);
    import regfile_pkg::*;

    logic [DATA_W-1:0] w_regs [NREGS];

    assign w_regs = '{r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15};
    assign sel    = regEnable[addr] ? ALUBus : w_regs[addr];
endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: two-operand fetch with forwarding and a one-deep tracked response stage
module regfile_read_port #(
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [regfile_pkg::RADDR_W-1:0] raddr_a,
    input  logic [regfile_pkg::RADDR_W-1:0] raddr_b,
    input  logic [DATA_W-1:0]               r0,
    input  logic [DATA_W-1:0]               r1,
    input  logic [DATA_W-1:0]               r2,
    input  logic [DATA_W-1:0]               r3,
    input  logic [DATA_W-1:0]               r4,
    input  logic [DATA_W-1:0]               r5,
    input  logic [DATA_W-1:0]               r6,
    input  logic [DATA_W-1:0]               r7,
    input  logic [DATA_W-1:0]               r8,
    input  logic [DATA_W-1:0]               r9,
    input  logic [DATA_W-1:0]               r10,
    input  logic [DATA_W-1:0]               r11,
    input  logic [DATA_W-1:0]               r12,
    input  logic [DATA_W-1:0]               r13,
    input  logic [DATA_W-1:0]               r14,
    input  logic [DATA_W-1:0]               r15,
    input  logic [DATA_W-1:0]               ALUBus,
    input  logic [regfile_pkg::NREGS-1:0]   regEnable,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_W-1:0]               op_a,
    output logic [DATA_W-1:0]               op_b,
    output logic [regfile_pkg::RADDR_W-1:0] rsp_addr_a,
    output logic [regfile_pkg::RADDR_W-1:0] rsp_addr_b
);
    import regfile_pkg::*;

    logic               r_valid;
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;
    logic [RADDR_W-1:0] r_addr_a;
    logic [RADDR_W-1:0] r_addr_b;
    logic               w_acc;
    logic [DATA_W-1:0]  w_sel_a;
    logic [DATA_W-1:0]  w_sel_b;

    assign req_ready = !r_valid || rsp_ready;
    assign w_acc     = req_valid && req_ready;

    regfile_sel #(.DATA_W(DATA_W)) u_sel_a (
        .addr(raddr_a), .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
        .ALUBus(ALUBus), .regEnable(regEnable), .sel(w_sel_a)
    );

    regfile_sel #(.DATA_W(DATA_W)) u_sel_b (
        .addr(raddr_b), .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
        .ALUBus(ALUBus), .regEnable(regEnable), .sel(w_sel_b)
    );

    // A stalled response keeps following writes to its registers; a consumed one does not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
        end else if (w_acc) begin
            r_valid  <= 1'b1;
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_addr_a <= raddr_a;
            r_addr_b <= raddr_b;
        end else if (rsp_ready) begin
            r_valid  <= 1'b0;
        end else if (r_valid) begin
            r_op_a   <= regEnable[r_addr_a] ? ALUBus : r_op_a;
            r_op_b   <= regEnable[r_addr_b] ? ALUBus : r_op_b;
        end
    end

    assign rsp_valid  = r_valid;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign rsp_addr_a = r_addr_a;
    assign rsp_addr_b = r_addr_b;
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: directed and random checks against a register-bank level model
module tb_regfile_read_port;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic [15:0] bank [16];
    logic [15:0] alu;
    logic [15:0] reg_en;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  rsp_addr_a;
    logic [3:0]  rsp_addr_b;

    logic        m_valid;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [3:0]  m_addr_a;
    logic [3:0]  m_addr_b;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    regfile_read_port dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .r0(bank[0]), .r1(bank[1]), .r2(bank[2]), .r3(bank[3]), .r4(bank[4]), .r5(bank[5]),
        .r6(bank[6]), .r7(bank[7]), .r8(bank[8]), .r9(bank[9]), .r10(bank[10]), .r11(bank[11]),
        .r12(bank[12]), .r13(bank[13]), .r14(bank[14]), .r15(bank[15]),
        .ALUBus(alu), .regEnable(reg_en), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .op_a(op_a), .op_b(op_b), .rsp_addr_a(rsp_addr_a), .rsp_addr_b(rsp_addr_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: operands equal the bank's post-write contents at accept and while stalled.
    task automatic step();
        logic acc;
        @(negedge clk);
        acc = req_valid && (!m_valid || rsp_ready);
        for (int i = 0; i < 16; i++) if (reg_en[i]) bank[i] = alu;
        if (!reset) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_addr_a = '0; m_addr_b = '0;
        end else if (acc) begin
            m_valid = 1'b1; m_addr_a = raddr_a; m_addr_b = raddr_b;
            m_a = bank[raddr_a]; m_b = bank[raddr_b];
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_a = bank[m_addr_a]; m_b = bank[m_addr_b];
        end
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("op_a", 32'(op_a), 32'(m_a));
        check("op_b", 32'(op_b), 32'(m_b));
        check("rsp_addr_a", 32'(rsp_addr_a), 32'(m_addr_a));
        check("rsp_addr_b", 32'(rsp_addr_b), 32'(m_addr_b));
        check("req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
    endtask

    task automatic drive(input logic rv, input logic rr, input logic [3:0] a, input logic [3:0] b,
                         input logic [15:0] en, input logic [15:0] d);
        req_valid = rv; rsp_ready = rr; raddr_a = a; raddr_b = b; reg_en = en; alu = d;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 16'($urandom);
        m_valid = 1'b0; m_a = '0; m_b = '0; m_addr_a = '0; m_addr_b = '0;
        reset = 1'b0;
        drive(1'b1, 1'b0, 4'd3, 4'd4, 16'h0, 16'h0);
        step();
        step();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_a", 32'(op_a), 32'h0);
        check("rst_op_b", 32'(op_b), 32'h0);
        check("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;
        bank[3] = 16'h1234;
        drive(1'b1, 1'b1, 4'd3, 4'd4, 16'h0, 16'h0);
        step();
        check("post_rst_op_a", 32'(op_a), 32'h1234);
        bank[5] = 16'h00AA; bank[6] = 16'h0066;
        drive(1'b1, 1'b1, 4'd5, 4'd6, 16'h0020, 16'hBEEF);
        step();
        check("fwd_op_a", 32'(op_a), 32'hBEEF);
        check("fwd_op_b", 32'(op_b), 32'h0066);
        drive(1'b1, 1'b1, 4'd2, 4'd7, 16'h0, 16'h0);
        step();
        drive(1'b1, 1'b0, 4'd9, 4'd9, 16'h0080, 16'h5A5A);
        step();
        check("stall_op_b", 32'(op_b), 32'h5A5A);
        check("stall_ready1", 32'(req_ready), 32'd0);
        drive(1'b1, 1'b0, 4'd9, 4'd9, 16'h0004, 16'h0F0F);
        step();
        check("stall_op_a", 32'(op_a), 32'h0F0F);
        check("stall_ready2", 32'(req_ready), 32'd0);
        check("stall_addr_a", 32'(rsp_addr_a), 32'd2);
        for (int i = 0; i < 4; i++) begin
            bank[i] = 16'h1000 + 16'(i);
            drive(1'b1, 1'b1, 4'(i), 4'(i), 16'h0, 16'h0);
            step();
            check("b2b_valid", 32'(rsp_valid), 32'd1);
            check("b2b_op_a", 32'(op_a), 32'h1000 + 32'(i));
        end
        bank[4] = 16'h4444;
        drive(1'b1, 1'b1, 4'd4, 4'd1, 16'h0, 16'h0);
        step();
        drive(1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        step();
        drive(1'b0, 1'b1, 4'd0, 4'd0, 16'h0010, 16'h7777);
        step();
        check("consume_valid", 32'(rsp_valid), 32'd0);
        check("consume_op_a", 32'(op_a), 32'h4444);
        bank[9] = 16'h9999;
        drive(1'b1, 1'b1, 4'd9, 4'd9, 16'h0, 16'h0);
        step();
        drive(1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        step();
        reset = 1'b0;
        step();
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_op_a", 32'(op_a), 32'h0);
        check("mid_rst_op_b", 32'(op_b), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) != 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  4'($urandom), 4'($urandom),
                  ($urandom_range(0, 2) == 0) ? 16'($urandom) & 16'($urandom)
                      : (($urandom_range(0, 1) == 1) ? 16'(1 << $urandom_range(0, 15)) : 16'h0),
                  16'($urandom));
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_read_port.md
# regfile_read_port

Read-side companion to the 16×16 register bank: accepts operand-fetch requests naming two source registers, selects their contents from the bank outputs `r0`..`r15`, and returns both operands through a one-deep registered response stage with valid/ready handshakes. It forwards same-cycle bank writes, taken from `ALUBus` under `regEnable`, so a returned operand always equals the register's post-write value. A stalled response also tracks later writes, so held operands never go stale. It sits between the decode stage (request side) and the ALU operand inputs (response side).

## Interface
Parameters:
- `DATA_W`, 16, operand/register width; must match bank width.

Ports:
- `clk`  in  1  rising-edge clock, shared with the register bank.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `raddr_a`  in  4  source register index for operand A.
- `raddr_b`  in  4  source register index for operand B.
- `r0`..`r15`  in  DATA_W each  current register bank outputs.
- `ALUBus`  in  DATA_W  bank write data this cycle.
- `regEnable`  in  16  bank write enables this cycle; more than one bit may be set, and all set registers receive `ALUBus`.
- `rsp_valid`  out  1  response stage holds valid operands.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `op_a`, `op_b`  out  DATA_W  operand values.
- `rsp_addr_a`, `rsp_addr_b`  out  4  indices echoed with the response.

## Operation
- Accept condition: `acc = req_valid && req_ready`.
- Ready rule: `req_ready = !rsp_valid || rsp_ready`. This is combinational and depends on no other input.
- Operand select on accept, shown for A (B is identical):
  - If `regEnable[raddr_a]` is set, `op_a` <= `ALUBus`.
  - Otherwise `op_a` <= `r[raddr_a]`.
  - `raddr_a == raddr_b` is legal; both operands then get the same value.
- Hold tracking: while `rsp_valid && !rsp_ready`, on every cycle with `regEnable[rsp_addr_a]` set, `op_a` <= `ALUBus`. The same applies to B. Addresses and `rsp_valid` are unchanged.
- Response stage states:
  - EMPTY (`rsp_valid`=0):
    - `acc` → FULL.
  - FULL (`rsp_valid`=1):
    - `rsp_ready && acc` → FULL with the new request (back-to-back, no bubble).
    - `rsp_ready && !acc` → EMPTY.
    - `!rsp_ready` → FULL, with hold tracking.
- Simultaneous events:
  - A write to the addressed register in the accept cycle is forwarded.
  - A write in the cycle the response is consumed affects only the next request; the departing response is not updated.
- In EMPTY, `op_*` and `rsp_addr_*` keep their last values. Inputs are ignored except on accept.
- There is no arithmetic; all paths are width-exact DATA_W.

## Timing
- Reset (`reset`=0 at a rising edge) sets:
  - `rsp_valid`=0;
  - `op_a`=`op_b`=0;
  - `rsp_addr_a`=`rsp_addr_b`=0.
- `req_ready` reads 1 in the reset cycle and after it, because it is combinational from `rsp_valid`=0.
- Reset mid-operation drops any held response; no handshake completes on that edge.
- Latency: request accepted at edge N → `rsp_valid`=1 with operands after edge N.
- Throughput: one request per cycle when `rsp_ready` is held high.
- Path constraints:
  - All outputs except `req_ready` are registered.
  - `req_ready` depends only on `rsp_valid` and `rsp_ready`; there is no path from `req_valid` to `req_ready`.

## Structure
- Shared package `regfile_pkg`: `DATA_W` default, `NREGS`=16, `RADDR_W`=4.
- Sub-module `regfile_sel`: a combinational 16:1 DATA_W mux with forward override. Inputs are `addr`, `r0`..`r15`, `ALUBus` and `regEnable`; output is `sel`. It is instantiated twice, once for A and once for B.
- The parent holds the response registers and the hold-tracking logic.

## Test plan
- Reset:
  - Stimulus: `reset`=0 for 2 cycles with `req_valid`=1.
  - Response: `rsp_valid`=0, `op_a`=`op_b`=0x0000, `req_ready`=1. After release, a request with `r3`=0x1234 and `raddr_a`=3 gives `op_a`=0x1234 one cycle later.
- Forwarding:
  - Stimulus: `r5`=0x00AA, `regEnable`=0x0020, `ALUBus`=0xBEEF, accept with `raddr_a`=5, `raddr_b`=6 (`r6`=0x0066).
  - Response: `op_a`=0xBEEF, `op_b`=0x0066.
- Stall tracking:
  - Stimulus: a response is held for addresses A=2, B=7 with `rsp_ready`=0. Then write r7 with `ALUBus`=0x5A5A, then write r2 with 0x0F0F.
  - Response: `op_b`=0x5A5A the cycle after the first write, `op_a`=0x0F0F the cycle after the second, and `req_ready`=0 throughout.
- Back-to-back:
  - Stimulus: 4 consecutive requests with `rsp_ready`=1, addresses 0..3, bank holding values 0x1000+i.
  - Response: 4 consecutive `rsp_valid` cycles with `op_a`=0x1000..0x1003 and no bubble.
- Consume-cycle write:
  - Stimulus: write r4 with 0x7777 in the same cycle the held response for A=4 is consumed (`rsp_ready`=1, no new request).
  - Response: the consumed `op_a` keeps its old value, and `rsp_valid`=0 the next cycle.
- Reset mid-stall:
  - Stimulus: while FULL and stalled, assert `reset`=0 for one cycle.
  - Response: `rsp_valid`=0 and `op_*`=0 the next cycle, and `req_ready`=1.
